iter_mul_unit: RTL
==================

# iter_mul_unit

Iterative shift-add multiplier for the multicycle datapath. It accepts two W-bit operands on a one-cycle Start strobe and computes the full 2W-bit product over W clock cycles. Done marks when the result is valid, so the downstream W-bit result register can load ProductLo in that cycle. The unit holds its result until the next accepted Start, which lets the controller sequence it like any other multicycle functional unit.

## Interface
- W, 16: operand width in bits; legal range 4..32.
- Clock  input  1  rising-edge clock.
- Reset  input  1  asynchronous, active-low reset.
- Start  input  1  one-cycle request. Sampled only in IDLE or DONE.
- A  input  W  multiplicand, captured on the accepting edge.
- B  input  W  multiplier, captured on the accepting edge.
- Busy  output  1  high while in RUN.
- Done  output  1  high for exactly one cycle, in DONE.
- ProductHi  output  W  upper half of the product.
- ProductLo  output  W  lower half of the product; this is what the result register loads.
- Overflow  output  1  the product does not fit in W bits.

## Operation
- States: IDLE, RUN, DONE.
- Reset asserted (Reset=0): state goes to IDLE; ProductHi=0, ProductLo=0, Busy=0, Done=0, Overflow=0, step counter=0.
- IDLE, Start=1: capture A and B, clear the accumulator, counter=0, go to RUN. With Start=0, stay in IDLE.
- RUN, each cycle:
  - If the current multiplier LSB is 1, add the multiplicand to the upper half of the accumulator, using a (W+1)-bit sum so no carry is lost.
  - Shift the {carry, accumulator} right by one.
  - Increment the counter.
- RUN exit: after the W-th step, load ProductHi/ProductLo and Overflow, then go to DONE.
- DONE, one cycle with Done=1:
  - Start=1: capture new operands and go to RUN. Back-to-back operation needs no idle gap.
  - Otherwise go to IDLE.
- Start in RUN is ignored; it is not queued. Operand changes after the capture edge have no effect.
- ProductHi, ProductLo and Overflow hold their values from DONE until the DONE of the next operation. They are never updated mid-RUN.
- Overflow (unsigned) = |ProductHi.
- Reset mid-RUN aborts the operation and clears every output immediately, with no clock edge required.

## Timing
- Start high at edge k (state IDLE or DONE): Busy=1 during cycles k..k+W-1.
- Results and Done=1 are valid after edge k+W, for one cycle. Busy=0 in that cycle.
- Latency from Start to Done is W+1 cycles. Throughput is one result per W+1 cycles.
- Done and Busy are never high together.
- The counter is ceil(log2(W))+1 bits wide and never wraps within an operation.

## Configuration
- Macro: MUL_SIGNED_EN.
- Defined: operands are two's complement.
  - At capture, A and B are replaced by their magnitudes and the result sign (A[W-1]^B[W-1]) is recorded.
  - At the RUN to DONE transition the 2W-bit magnitude is negated if the sign is 1.
  - Overflow is 1 when ProductHi is not all copies of ProductLo[W-1].
  - The most-negative operand (-2^(W-1)) is handled exactly because magnitudes use W+1 bits internally.
  - Latency is unchanged.
- Undefined: unsigned only; no sign logic is synthesized.

## Test plan
- Reset: drive Reset=0 mid-RUN with A=0x1234, B=0x0056 -> all outputs 0 immediately and state IDLE; the next Start gives a correct result.
- Unsigned, W=16: A=0x00FF, B=0x0101 -> ProductLo=0xFFFF, ProductHi=0x0000, Overflow=0, Done after exactly 17 cycles.
- Unsigned overflow: A=0xFFFF, B=0xFFFF -> ProductHi=0xFFFE, ProductLo=0x0001, Overflow=1.
- Handshake:
  - Start pulsed during RUN with A=B=0x0002 -> ignored; the first result is unchanged.
  - Start asserted in the DONE cycle with A=3, B=5 -> second Done with ProductLo=0x000F, 17 cycles after the first Done.
- MUL_SIGNED_EN: A=0xFFFD (-3), B=0x0005 -> {ProductHi,ProductLo}=0xFFFFFFF1, Overflow=0.
- MUL_SIGNED_EN, most-negative operands: A=0x8000, B=0x8000 -> 0x40000000, Overflow=1.

Source files
------------

// File: rtl/iter_mul_unit.sv
// iter_mul_unit: iterative shift-add multiplier producing a 2W-bit product over
// W RUN cycles. Result, Done and Overflow are valid in the single DONE cycle and
// hold until the next operation completes.
// Optional build macro MUL_SIGNED_EN: two's-complement operands (sign-magnitude
// around the unsigned core). Without it the unit is unsigned only.
module iter_mul_unit #(
   parameter int W = 16
) (
   input  logic         Clock,
   input  logic         Reset,
   input  logic         Start,
   input  logic [W-1:0] A,
   input  logic [W-1:0] B,
   output logic         Busy,
   output logic         Done,
   output logic [W-1:0] ProductHi,
   output logic [W-1:0] ProductLo,
   output logic         Overflow
);

   // Step counter is wide enough to hold W itself, so it never wraps mid-operation.
   localparam int CW = $clog2(W) + 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            ovf_q, ovf_d;
   logic [W-1:0]    hi_q, hi_d;
   logic [W-1:0]    lo_q, lo_d;

   // Datapath: multiplicand, and accumulator whose low half starts as the multiplier.
   logic [W-1:0]    mcand_q, mcand_d;
   logic [2*W-1:0]  acc_q, acc_d;

   logic [W-1:0]    a_cap, b_cap;
   logic [W:0]      sum;
   logic [2*W-1:0]  acc_step;
   logic [2*W-1:0]  prod;

`ifdef MUL_SIGNED_EN
   logic            neg_q, neg_d;

   // Magnitude computed in W+1 bits so -2^(W-1) maps to 2^(W-1) exactly; the
   // result always fits back into W unsigned bits.
   function automatic logic [W-1:0] magnitude(input logic signed [W-1:0] v);
      logic signed [W:0] ext;
      ext = {v[W-1], v};
      if (v[W-1]) ext = -ext;
      return ext[W-1:0];
   endfunction

   // Re-apply the recorded result sign to the unsigned 2W-bit magnitude.
   function automatic logic [2*W-1:0] apply_sign(input logic [2*W-1:0] mag,
                                                 input logic neg);
      return neg ? -mag : mag;
   endfunction
`endif

   // Operand conditioning at capture time.
   always_comb begin
`ifdef MUL_SIGNED_EN
      a_cap = magnitude(A);
      b_cap = magnitude(B);
`else
      a_cap = A;
      b_cap = B;
`endif
   end

   // One shift-add step: conditional add into the upper half with carry, then shift right.
   always_comb begin
      sum      = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, mcand_q} : {(W+1){1'b0}});
      acc_step = {sum, acc_q[W-1:1]};
`ifdef MUL_SIGNED_EN
      prod     = apply_sign(acc_step, neg_q);
`else
      prod     = acc_step;
`endif
   end

   // Next-state and next-output logic for the IDLE/RUN/DONE sequencer.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      ovf_d   = ovf_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      mcand_d = mcand_q;
      acc_d   = acc_q;
`ifdef MUL_SIGNED_EN
      neg_d   = neg_q;
`endif
      unique case (state_q)
         S_IDLE, S_DONE: begin
            if (Start) begin
               mcand_d = a_cap;
               acc_d   = {{W{1'b0}}, b_cap};
`ifdef MUL_SIGNED_EN
               neg_d   = A[W-1] ^ B[W-1];
`endif
               cnt_d   = '0;
               busy_d  = 1'b1;
               state_d = S_RUN;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_RUN: begin
            acc_d = acc_step;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(W - 1)) begin
               hi_d    = prod[2*W-1:W];
               lo_d    = prod[W-1:0];
`ifdef MUL_SIGNED_EN
               ovf_d   = (prod[2*W-1:W] != {W{prod[W-1]}});
`else
               ovf_d   = |prod[2*W-1:W];
`endif
               done_d  = 1'b1;
               state_d = S_DONE;
            end else begin
               busy_d  = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Control state and visible outputs; reset clears them without waiting for a clock.
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         ovf_q   <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         ovf_q   <= ovf_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   // Datapath registers; always reloaded on Start, so they need no reset.
   always_ff @(posedge Clock) begin
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
`ifdef MUL_SIGNED_EN
      neg_q   <= neg_d;
`endif
   end

   assign Busy      = busy_q;
   assign Done      = done_q;
   assign ProductHi = hi_q;
   assign ProductLo = lo_q;
   assign Overflow  = ovf_q;

endmodule
